// File: rtl/mfcc_frame_scheduler.sv
// mfcc_frame_scheduler
//   Buffers pre-emphasised PCM samples in a circular RAM and replays them as
//   overlapping frames for the window/FFT stage. Each frame is FRAME_SIZE real
//   samples followed by FFT_SIZE-FRAME_SIZE zeros; frame starts are FRAME_MOVE
//   samples apart. Output is a valid/ready stream fed by a prefetching read
//   port plus a one-entry skid register, so it sustains one sample per cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pcm_in            input sample, qualified by pcm_ready_i (1-cycle strobe)
//   frame_sample_o    output sample (zero during padding)
//   frame_valid_o     output valid; frame_ready_i is the downstream accept
//   frame_start_o     index 0 of a frame; frame_last_o index FFT_SIZE-1
//   sample_idx_o      index of the output sample within its frame
//   overflow_o        sticky, set when an input sample is dropped
//   frame_count_o     completed-frame counter (only with MFCC_SCHED_FRAME_CNT_EN)
//
// Build option: define MFCC_SCHED_FRAME_CNT_EN to add frame_count_o.
module mfcc_frame_scheduler #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 400,
  parameter int FRAME_MOVE   = 160,
  parameter int FFT_SIZE     = 512,
  parameter int BUF_DEPTH    = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SAMPLE_WIDTH-1:0]     pcm_in,
  input  logic                        pcm_ready_i,
  output logic [SAMPLE_WIDTH-1:0]     frame_sample_o,
  output logic                        frame_valid_o,
  input  logic                        frame_ready_i,
  output logic                        frame_start_o,
  output logic                        frame_last_o,
  output logic [$clog2(FFT_SIZE)-1:0] sample_idx_o,
  output logic                        overflow_o
`ifdef MFCC_SCHED_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_count_o
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int IW = $clog2(FFT_SIZE);
  localparam int CW = IW + 1;

  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   FS_OCC_C    = (AW+1)'(FRAME_SIZE);
  localparam logic [AW:0]   MOVE_OCC_C  = (AW+1)'(FRAME_MOVE);
  localparam logic [AW-1:0] MOVE_PTR_C  = AW'(FRAME_MOVE);
  localparam logic [CW-1:0] FS_CNT_C    = CW'(FRAME_SIZE);
  localparam logic [CW-1:0] FFT_CNT_C   = CW'(FFT_SIZE);
  localparam logic [IW-1:0] LAST_REAL_C = IW'(FRAME_SIZE - 1);
  localparam logic [IW-1:0] LAST_IDX_C  = IW'(FFT_SIZE - 1);
  localparam bit            NO_PAD_C    = (FRAME_SIZE == FFT_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SAMPLE_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [SAMPLE_WIDTH-1:0] ram_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_ptr_q, base_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [CW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic          overflow_q, overflow_d;

  // Read-return stage: a RAM read issued last cycle lands this cycle.
  logic          rv_q, rv_d;
  logic [IW-1:0] rv_idx_q, rv_idx_d;
  logic          rv_pad_q, rv_pad_d;

  logic                    out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]           out_idx_q, out_idx_d;
  logic                    out_start_q, out_start_d;
  logic                    out_last_q, out_last_d;

  logic                    skid_valid_q, skid_valid_d;
  logic [SAMPLE_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [IW-1:0]           skid_idx_q, skid_idx_d;

  logic                    hs_s, wr_en_s, fetching_s, held2_s, issue_s, advance_s;
  logic [SAMPLE_WIDTH-1:0] land_data_s;

  assign hs_s        = out_valid_q & frame_ready_i;
  assign wr_en_s     = pcm_ready_i & (occ_q != DEPTH_C);
  assign fetching_s  = (state_q != IDLE) & (fetch_cnt_q != FFT_CNT_C);
  // Two items already held or in flight: only issue if one leaves this cycle.
  assign held2_s     = out_valid_q & (skid_valid_q | rv_q);
  assign issue_s     = fetching_s & (~held2_s | hs_s);
  assign land_data_s = rv_pad_q ? {SAMPLE_WIDTH{1'b0}} : ram_q;

  // Sample buffer: write port from PCM side, registered read port for prefetch.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= pcm_in;
    if (issue_s) ram_q <= mem_q[rd_ptr_q];
  end

  // Next-state logic: write side, prefetch, output/skid stage and frame FSM.
  always_comb begin
    state_d      = state_q;
    base_ptr_d   = base_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_cnt_d  = fetch_cnt_q;
    rv_d         = 1'b0;
    rv_idx_d     = rv_idx_q;
    rv_pad_d     = rv_pad_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_idx_d   = skid_idx_q;
    advance_s    = 1'b0;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    overflow_d = overflow_q | (pcm_ready_i & ~wr_en_s);

    // Prefetch: real samples advance the read pointer, pad slots do not.
    if (issue_s) begin
      rv_d        = 1'b1;
      rv_idx_d    = fetch_cnt_q[IW-1:0];
      rv_pad_d    = (fetch_cnt_q >= FS_CNT_C);
      fetch_cnt_d = fetch_cnt_q + CW'(1);
      if (fetch_cnt_q < FS_CNT_C) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end else begin
      rv_d = 1'b0;
    end

    // Output register refills from skid first, then from the RAM return.
    if (hs_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_idx_d    = skid_idx_q;
        skid_valid_d = rv_q;
        skid_data_d  = land_data_s;
        skid_idx_d   = rv_idx_q;
      end else if (rv_q) begin
        out_valid_d = 1'b1;
        out_data_d  = land_data_s;
        out_idx_d   = rv_idx_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rv_q) begin
      if (out_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = land_data_s;
        skid_idx_d   = rv_idx_q;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = land_data_s;
        out_idx_d   = rv_idx_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    out_start_d = out_valid_d & (out_idx_d == {IW{1'b0}});
    out_last_d  = out_valid_d & (out_idx_d == LAST_IDX_C);

    // Frame FSM follows the output handshakes; fetch runs ahead of it.
    case (state_q)
      IDLE: begin
        if (occ_q >= FS_OCC_C) begin
          state_d     = EMIT;
          rd_ptr_d    = base_ptr_q;
          fetch_cnt_d = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (hs_s && (out_idx_q == LAST_REAL_C)) begin
          if (NO_PAD_C) begin
            state_d   = IDLE;
            advance_s = 1'b1;
          end else begin
            state_d = PAD;
          end
        end else begin
          state_d = EMIT;
        end
      end
      PAD: begin
        if (hs_s && out_last_q) begin
          state_d   = IDLE;
          advance_s = 1'b1;
        end else begin
          state_d = PAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance_s) begin
      base_ptr_d = base_ptr_q + MOVE_PTR_C;
    end else begin
      base_ptr_d = base_ptr_q;
    end
    // Occupancy is tracked explicitly so a full buffer is distinct from empty.
    occ_d = occ_q + {{AW{1'b0}}, wr_en_s} - (advance_s ? MOVE_OCC_C : {(AW+1){1'b0}});
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {AW{1'b0}};
      base_ptr_q   <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      occ_q        <= {(AW+1){1'b0}};
      fetch_cnt_q  <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      rv_q         <= 1'b0;
      rv_idx_q     <= {IW{1'b0}};
      rv_pad_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {SAMPLE_WIDTH{1'b0}};
      out_idx_q    <= {IW{1'b0}};
      out_start_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= {SAMPLE_WIDTH{1'b0}};
      skid_idx_q   <= {IW{1'b0}};
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_ptr_q   <= base_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      fetch_cnt_q  <= fetch_cnt_d;
      overflow_q   <= overflow_d;
      rv_q         <= rv_d;
      rv_idx_q     <= rv_idx_d;
      rv_pad_q     <= rv_pad_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_start_q  <= out_start_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_idx_q   <= skid_idx_d;
    end
  end

  assign frame_sample_o = out_data_q;
  assign frame_valid_o  = out_valid_q;
  assign frame_start_o  = out_start_q;
  assign frame_last_o   = out_last_q;
  assign sample_idx_o   = out_idx_q;
  assign overflow_o     = overflow_q;

`ifdef MFCC_SCHED_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Completed frames: one count per accepted last sample, wrapping at 16 bits.
  always_comb begin
    if (hs_s && out_last_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count_o = frame_count_q;
`endif

endmodule
